// File: rtl/tpu_pkg.sv
// Shared TPU definitions used by the MAC array and its A/B/C feeders.
//   BITS_AB  - signed operand width
//   DIM      - systolic array dimension (rows == row length)
//   CNTBITS  - row-index width, clog2(DIM)
//   state_t  - feeder FSM states
//   slot_bits() / SLOTBITS - width of a slot counter spanning 0..2*DIM-2
package tpu_pkg;

  localparam int BITS_AB = 8;
  localparam int DIM     = 8;
  localparam int CNTBITS = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // A skewed stream of a DIMxDIM matrix lasts 2*DIM-1 slots.
  function automatic int slot_bits(input int dim);
    if (2 * dim - 1 > 1) return $clog2(2 * dim - 1);
    else return 1;
  endfunction

  localparam int SLOTBITS = slot_bits(DIM);

endpackage

// File: rtl/tpu_skew_row.sv
// One row of the skew feeder: DIM-element storage for A[ROW][*] plus the
// slot-select mux that emits A[ROW][slot-ROW], or 0 outside the row's window.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (clears storage)
//   wr_en       - write this row (already decoded by the top level)
//   wr_data     - DIM elements, wr_data[j] = A[ROW][j]
//   slot        - slot index whose element is to be presented
//   row_out     - selected element (combinational; registered by the top)
module tpu_skew_row #(
  parameter int BITS_AB = tpu_pkg::BITS_AB,
  parameter int DIM     = tpu_pkg::DIM,
  parameter int ROW     = 0
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      wr_en,
  input  logic signed [DIM-1:0][BITS_AB-1:0]        wr_data,
  input  logic [tpu_pkg::slot_bits(DIM)-1:0]        slot,
  output logic signed [BITS_AB-1:0]                 row_out
);

  logic signed [DIM-1:0][BITS_AB-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '0;
    else        mem_q <= mem_d;
  end

  // Row ROW is delayed ROW slots: element j appears at slot ROW+j.
  always_comb begin
    row_out = '0;
    for (int j = 0; j < DIM; j++) begin
      if (int'(slot) == ROW + j) row_out = mem_q[j];
    end
  end

endmodule

// File: rtl/tpu_skew_feeder.sv
// Upstream A-operand feeder for the systolic MAC array. Holds a DIMxDIM
// signed matrix and streams it with diagonal skew (row i delayed i cycles),
// advancing in lockstep with the array through the shared en stall.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   en              - array advance enable (stall when low)
//   wr_en, wr_row,
//   wr_data         - write one row of A (IDLE only)
//   start           - begin one skewed stream (IDLE, en=1, wr_en=0)
//   a_out           - a_out[i] drives array row i Ain (registered)
//   a_valid         - a_out carries a stream slot
//   busy            - stream in progress
//   done            - one-cycle pulse after the last slot
module tpu_skew_feeder #(
  parameter int BITS_AB = tpu_pkg::BITS_AB,
  parameter int DIM     = tpu_pkg::DIM,
  parameter int CNTBITS = tpu_pkg::CNTBITS
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               en,
  input  logic                               wr_en,
  input  logic [CNTBITS-1:0]                 wr_row,
  input  logic signed [DIM-1:0][BITS_AB-1:0] wr_data,
  input  logic                               start,
  output logic signed [DIM-1:0][BITS_AB-1:0] a_out,
  output logic                               a_valid,
  output logic                               busy,
  output logic                               done
);

  import tpu_pkg::*;

  localparam int             SW   = slot_bits(DIM);
  localparam logic [SW-1:0]  LAST = SW'(2 * DIM - 2);

  state_t                             state_q, state_d;
  logic [SW-1:0]                      t_q, t_d;
  logic                               valid_q, valid_d;
  logic                               done_q, done_d;
  logic signed [DIM-1:0][BITS_AB-1:0] a_out_q, a_out_d;
  logic signed [DIM-1:0][BITS_AB-1:0] mux_out;
  logic [DIM-1:0]                     row_we;

  // FSM and slot counter. A start coinciding with a write loses to the write.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && en && !wr_en) begin
          state_d = STREAM;
          t_d     = '0;
        end
      end
      STREAM: begin
        if (en) begin
          if (t_q == LAST) begin
            state_d = IDLE;
            t_d     = '0;
            done_d  = 1'b1;
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
    valid_d = (state_d == STREAM);
  end

  // Storage is frozen while streaming so the slot mux sees a stable matrix.
  always_comb begin
    row_we = '0;
    for (int i = 0; i < DIM; i++) begin
      row_we[i] = (state_q == IDLE) && wr_en && (int'(wr_row) == i);
    end
  end

  for (genvar i = 0; i < DIM; i++) begin : g_row
    tpu_skew_row #(
      .BITS_AB (BITS_AB),
      .DIM     (DIM),
      .ROW     (i)
    ) u_row (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (row_we[i]),
      .wr_data (wr_data),
      .slot    (t_d),
      .row_out (mux_out[i])
    );
  end

  // The mux looks at the next slot so a_out can be registered without an
  // extra cycle of latency; during a stall t_d == t_q and the value holds.
  always_comb begin
    a_out_d = '0;
    if (state_d == STREAM) a_out_d = mux_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      a_out_q <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      a_out_q <= a_out_d;
    end
  end

  assign a_out   = a_out_q;
  assign a_valid = valid_q;
  assign busy    = valid_q;
  assign done    = done_q;

endmodule

// File: tb/tb_tpu_skew_feeder.sv
module tb_tpu_skew_feeder;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    en;
  logic                    wr_en;
  logic [2:0]              wr_row;
  logic signed [7:0][7:0]  wr_data;
  logic                    start;
  logic signed [7:0][7:0]  a_out;
  logic                    a_valid;
  logic                    busy;
  logic                    done;

  tpu_skew_feeder #(.BITS_AB(8), .DIM(8), .CNTBITS(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .start   (start),
    .a_out   (a_out),
    .a_valid (a_valid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [63:0] vec;
    bit          last;
  } slot_t;

  logic [7:0] mdl_a [8][8];
  slot_t      sb_q [$];
  logic       exp_done = 1'b0;
  int         valid_total = 0;

  // A stream of matrix M is 15 slots; slot t shows M[i][t-i] on row i.
  task automatic push_stream();
    for (int t = 0; t < 15; t++) begin
      logic [7:0][7:0] v;
      slot_t s;
      for (int i = 0; i < 8; i++) begin
        if (t - i >= 0 && t - i <= 7) v[i] = mdl_a[i][t - i];
        else v[i] = 8'h00;
      end
      s.vec  = v;
      s.last = (t == 14);
      sb_q.push_back(s);
    end
  endtask

  // Monitor: samples mid-cycle; inputs seen here are those the next edge uses.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_a_out", a_out, 64'h0);
      chk("rst_a_valid", {63'h0, a_valid}, 64'h0);
      chk("rst_busy", {63'h0, busy}, 64'h0);
      chk("rst_done", {63'h0, done}, 64'h0);
      sb_q.delete();
      exp_done = 1'b0;
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) mdl_a[i][j] = 8'h00;
    end else begin
      bit idle;
      logic [63:0] ev;
      idle = (sb_q.size() == 0);
      ev   = idle ? 64'h0 : sb_q[0].vec;
      chk("a_valid", {63'h0, a_valid}, {63'h0, !idle});
      chk("busy", {63'h0, busy}, {63'h0, !idle});
      chk("a_out", a_out, ev);
      chk("done", {63'h0, done}, {63'h0, exp_done});
      if (a_valid) valid_total++;
      exp_done = 1'b0;
      if (!idle) begin
        if (en) begin
          exp_done = sb_q[0].last;
          void'(sb_q.pop_front());
        end
      end else begin
        if (wr_en) begin
          for (int j = 0; j < 8; j++) mdl_a[int'(wr_row)][j] = wr_data[j];
        end else if (start && en) begin
          push_stream();
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input int r, input logic [63:0] d);
    wr_en   = 1'b1;
    wr_row  = 3'(r);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    for (k = 0; k < budget && busy; k++) tick();
    chk("idle_timeout", {63'h0, busy}, 64'h0);
  endtask

  function automatic logic [63:0] base_row(input int r);
    logic [7:0][7:0] v;
    for (int j = 0; j < 8; j++) v[j] = 8'(8 * r + j + 1);
    return v;
  endfunction

  initial begin
    int vt;
    logic [7:0][7:0] d;
    rst_n = 1'b0; en = 1'b0; wr_en = 1'b0; wr_row = 3'd0; wr_data = '0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    en    = 1'b1;
    tick();

    // 1: stream with nothing loaded -> zeros
    vt = valid_total;
    pulse_start();
    chk("s1_t0_a_out", a_out, 64'h0);
    wait_idle(40);
    chk("s1_len", 64'(valid_total - vt), 64'd15);
    tick();

    // 2: full stream
    for (int r = 0; r < 8; r++) write_row(r, base_row(r));
    vt = valid_total;
    pulse_start();
    chk("s2_t0_row0", {56'h0, a_out[0]}, 64'd1);
    chk("s2_t0_row1", {56'h0, a_out[1]}, 64'd0);
    tick();
    chk("s2_t1_row0", {56'h0, a_out[0]}, 64'd2);
    chk("s2_t1_row1", {56'h0, a_out[1]}, 64'd9);
    repeat (6) tick();
    chk("s2_t7_row3", {56'h0, a_out[3]}, 64'd29);
    wait_idle(40);
    chk("s2_done", {63'h0, done}, 64'd1);
    chk("s2_len", 64'(valid_total - vt), 64'd15);
    tick();

    // 3: stall 3 cycles at t=5
    vt = valid_total;
    pulse_start();
    repeat (5) tick();
    en = 1'b0;
    repeat (3) begin
      tick();
      chk("s3_stall_busy", {63'h0, busy}, 64'd1);
      chk("s3_stall_row5", {56'h0, a_out[5]}, 64'd41);
    end
    en = 1'b1;
    wait_idle(40);
    chk("s3_len", 64'(valid_total - vt), 64'd18);
    tick();

    // 4: writes and start ignored mid-stream; start+write in IDLE
    pulse_start();
    tick();
    wr_en = 1'b1; wr_row = 3'd0; wr_data = {64{1'b1}}; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    wait_idle(40);
    tick();
    pulse_start();
    chk("s4_restart_row0", {56'h0, a_out[0]}, 64'd1);
    wait_idle(40);
    tick();
    wr_en = 1'b1; wr_row = 3'd2; wr_data = {$urandom(), $urandom()}; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    chk("s4_wr_start_busy", {63'h0, busy}, 64'd0);
    tick();
    chk("s4_wr_start_busy2", {63'h0, busy}, 64'd0);

    // 5: signed extremes, back-to-back start in the done cycle
    d = base_row(0); d[0] = 8'h80; write_row(0, d);
    d = base_row(7); d[7] = 8'h7F; write_row(7, d);
    pulse_start();
    chk("s5_t0_row0", {56'h0, a_out[0]}, 64'h80);
    repeat (14) tick();
    chk("s5_t14_row7", {56'h0, a_out[7]}, 64'h7F);
    tick();
    chk("s5_done", {63'h0, done}, 64'd1);
    pulse_start();
    chk("s5_b2b_valid", {63'h0, a_valid}, 64'd1);
    chk("s5_b2b_row0", {56'h0, a_out[0]}, 64'h80);
    wait_idle(40);
    tick();

    // 6: reset mid-stream
    pulse_start();
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_a_out", a_out, 64'h0);
    chk("s6_rst_valid", {63'h0, a_valid}, 64'd0);
    chk("s6_rst_busy", {63'h0, busy}, 64'd0);
    chk("s6_rst_done", {63'h0, done}, 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    vt = valid_total;
    pulse_start();
    wait_idle(40);
    chk("s6_len", 64'(valid_total - vt), 64'd15);
    tick();

    // random traffic
    for (int r = 0; r < 8; r++) write_row(r, {$urandom(), $urandom()});
    repeat (400) begin
      en      = ($urandom_range(0, 3) != 0);
      wr_en   = ($urandom_range(0, 4) == 0);
      wr_row  = 3'($urandom_range(0, 7));
      wr_data = {$urandom(), $urandom()};
      start   = ($urandom_range(0, 4) == 0);
      tick();
    end
    en = 1'b1; wr_en = 1'b0; start = 1'b0;
    wait_idle(40);
    tick();
    chk("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
